// File: rtl/led_7seg_scan_ctrl_if.sv
// Display-side bus of the 7-segment scan controller: user load inputs plus the
// segment/select pin drive and status flags.
interface led_7seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   digit_data;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic [3:0]            brightness;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     sel;
  logic                  busy;
  logic                  frame_start;

  modport master (
    output load, digit_data, dp, blank_mask, blink_mask, brightness,
    input  seg, sel, busy, frame_start
  );

  modport slave (
    input  load, digit_data, dp, blank_mask, blink_mask, brightness,
    output seg, sel, busy, frame_start
  );
endinterface

// File: rtl/led_7seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: slot timer, guard time, 16-step PWM, blink,
// hex decode and double-buffered display registers committed at frame end.
module led_7seg_scan_ctrl #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned GUARD_CLKS     = 2000,
  parameter int unsigned STEP_CLKS      = 3000,
  parameter int unsigned BLINK_FRAMES   = 32,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  led_7seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned SLOT   = GUARD_CLKS + 16 * STEP_CLKS;
  localparam int unsigned SlotW  = $clog2(SLOT);
  localparam int unsigned DigW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SubW   = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(SLOT - 1);
  localparam logic [SlotW-1:0]  GuardEnd  = SlotW'(GUARD_CLKS);
  localparam logic [DigW-1:0]   DigLast   = DigW'(DIGITS - 1);
  localparam logic [SubW-1:0]   SubLast   = SubW'(STEP_CLKS - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);
  localparam logic [7:0]        SegOff    = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SelOff    = {DIGITS{SEL_ACTIVE_LOW}};

  // Scan timing state
  logic [SlotW-1:0]  slot_cnt_q;
  logic [DigW-1:0]   digit_idx_q;
  logic [3:0]        step_q;
  logic [SubW-1:0]   sub_q;
  logic [FrameW-1:0] frame_cnt_q;
  logic              blink_phase_q;

  // Active (displayed) and pending (loaded) buffers
  logic [4*DIGITS-1:0] act_data_q,  pend_data_q;
  logic [DIGITS-1:0]   act_dp_q,    pend_dp_q;
  logic [DIGITS-1:0]   act_blank_q, pend_blank_q;
  logic [DIGITS-1:0]   act_blink_q, pend_blink_q;
  logic                pend_valid_q;

  logic [7:0]        seg_q;
  logic [DIGITS-1:0] sel_q;
  logic              frame_start_q;

  logic              last_slot;
  logic              frame_end;
  logic              in_guard;
  logic [3:0]        nibble;
  logic              dark;
  logic              lit;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] sel_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    last_slot = (slot_cnt_q == SlotLast);
    frame_end = last_slot && (digit_idx_q == DigLast);
    in_guard  = (slot_cnt_q < GuardEnd);
    nibble    = act_data_q[{digit_idx_q, 2'b00} +: 4];
    dark      = act_blank_q[digit_idx_q] | (act_blink_q[digit_idx_q] & blink_phase_q);
    lit       = !in_guard && (step_q < bus.brightness) && !dark;
    seg_d     = SegOff;
    sel_d     = SelOff;
    if (lit) begin
      seg_d = {act_dp_q[digit_idx_q], hex_to_seg(nibble)} ^ SegOff;
      sel_d = (DIGITS'(1) << digit_idx_q) ^ SelOff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      step_q        <= '0;
      sub_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      act_data_q    <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      act_blink_q   <= '0;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_blink_q  <= '0;
      pend_valid_q  <= 1'b0;
      seg_q         <= SegOff;
      sel_q         <= SelOff;
      frame_start_q <= 1'b0;
    end else begin
      // step_q/sub_q track (slot_cnt - GUARD_CLKS) / STEP_CLKS without a divider
      if (last_slot) begin
        slot_cnt_q  <= '0;
        step_q      <= '0;
        sub_q       <= '0;
        digit_idx_q <= (digit_idx_q == DigLast) ? '0 : digit_idx_q + DigW'(1);
      end else begin
        slot_cnt_q <= slot_cnt_q + SlotW'(1);
        if (!in_guard) begin
          if (sub_q == SubLast) begin
            sub_q  <= '0;
            step_q <= step_q + 4'd1;
          end else begin
            sub_q <= sub_q + SubW'(1);
          end
        end
      end

      if (frame_end) begin
        if (frame_cnt_q == FrameLast) begin
          frame_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + FrameW'(1);
        end
      end

      // Commit takes the pending value from before this edge; a coincident load
      // then becomes the new pending value.
      if (frame_end && pend_valid_q) begin
        act_data_q   <= pend_data_q;
        act_dp_q     <= pend_dp_q;
        act_blank_q  <= pend_blank_q;
        act_blink_q  <= pend_blink_q;
        pend_valid_q <= 1'b0;
      end
      if (bus.load) begin
        pend_data_q  <= bus.digit_data;
        pend_dp_q    <= bus.dp;
        pend_blank_q <= bus.blank_mask;
        pend_blink_q <= bus.blink_mask;
        pend_valid_q <= 1'b1;
      end

      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_start_q <= (digit_idx_q == '0) && (slot_cnt_q == '0);
    end
  end

  assign bus.seg         = seg_q;
  assign bus.sel         = sel_q;
  assign bus.busy        = pend_valid_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_7seg_scan_ctrl.sv
// Directed bench for led_7seg_scan_ctrl: SLOT=18, frame=72 clocks, both
// polarities active-low; positions are output cycles counted from frame_start.
module tb_led_7seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_7seg_scan_ctrl_if #(.DIGITS(4)) bus ();

  led_7seg_scan_ctrl #(
    .DIGITS        (4),
    .GUARD_CLKS    (2),
    .STEP_CLKS     (1),
    .BLINK_FRAMES  (2),
    .SEG_ACTIVE_LOW(1'b1),
    .SEL_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int cur_pos = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next frame_start; the gap must be exactly the rest of the frame.
  task automatic sync_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 300);
    chk("frame_period", 16'(n), 16'(72 - cur_pos));
    cur_pos = 0;
  endtask

  task automatic goto_pos(input int p);
    while (cur_pos < p) begin
      @(negedge clk);
      cur_pos++;
    end
  endtask

  task automatic load_pulse(input logic [15:0] data, input logic [3:0] dpv,
                            input logic [3:0] blank, input logic [3:0] blink);
    bus.digit_data = data;
    bus.dp         = dpv;
    bus.blank_mask = blank;
    bus.blink_mask = blink;
    bus.load       = 1'b1;
    @(negedge clk);
    cur_pos++;
    bus.load = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_sel;
    logic [7:0] exp_seg;
    int         s;
    bus.load       = 1'b0;
    bus.digit_data = '0;
    bus.dp         = '0;
    bus.blank_mask = '0;
    bus.blink_mask = '0;
    bus.brightness = 4'd15;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_seg", 16'(bus.seg), 16'hFF);
    chk("rst_sel", 16'(bus.sel), 16'hF);
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_fs", 16'(bus.frame_start), 16'h0);
    rst     = 1'b0;
    cur_pos = 71;

    // F0: frame_start on the first output cycle, display blanked from reset
    sync_frame();
    goto_pos(20);
    chk("idle_sel", 16'(bus.sel), 16'hF);
    chk("idle_seg", 16'(bus.seg), 16'hFF);

    // F1: load, busy until commit at last clock of frame
    sync_frame();
    load_pulse(16'h3210, 4'h0, 4'h0, 4'h0);
    chk("busy_after_load", 16'(bus.busy), 16'h1);
    goto_pos(70);
    chk("busy_pos70", 16'(bus.busy), 16'h1);
    goto_pos(71);
    chk("busy_pos71", 16'(bus.busy), 16'h0);

    // F2: brightness 15
    sync_frame();
    chk("f2_busy", 16'(bus.busy), 16'h0);
    chk("d0_guard0_sel", 16'(bus.sel), 16'hF);
    chk("d0_guard0_seg", 16'(bus.seg), 16'hFF);
    goto_pos(1);
    chk("d0_guard1_sel", 16'(bus.sel), 16'hF);
    goto_pos(2);
    chk("d0_on_sel", 16'(bus.sel), 16'hE);
    chk("d0_on_seg", 16'(bus.seg), 16'hC0);
    goto_pos(16);
    chk("d0_last_on_sel", 16'(bus.sel), 16'hE);
    goto_pos(17);
    chk("d0_off_sel", 16'(bus.sel), 16'hF);
    goto_pos(20);
    chk("d1_sel", 16'(bus.sel), 16'hD);
    chk("d1_seg", 16'(bus.seg), 16'hF9);
    goto_pos(38);
    chk("d2_sel", 16'(bus.sel), 16'hB);
    chk("d2_seg", 16'(bus.seg), 16'hA4);
    goto_pos(56);
    chk("d3_sel", 16'(bus.sel), 16'h7);
    chk("d3_seg", 16'(bus.seg), 16'hB0);
    goto_pos(71);
    bus.brightness = 4'd4;

    // F3: brightness 4, then 0, then two loads in one frame
    sync_frame();
    goto_pos(5);
    chk("br4_step3_sel", 16'(bus.sel), 16'hE);
    goto_pos(6);
    chk("br4_step4_sel", 16'(bus.sel), 16'hF);
    bus.brightness = 4'd0;
    goto_pos(20);
    chk("br0_sel", 16'(bus.sel), 16'hF);
    chk("br0_seg", 16'(bus.seg), 16'hFF);
    goto_pos(21);
    bus.brightness = 4'd15;
    goto_pos(30);
    load_pulse(16'h1111, 4'h0, 4'h0, 4'h0);
    goto_pos(40);
    load_pulse(16'h2222, 4'h0, 4'h0, 4'h0);
    chk("busy_double", 16'(bus.busy), 16'h1);

    // F4: only 2222 visible across the frame, then a load in the commit cycle
    sync_frame();
    for (int p = 0; p < 70; p++) begin
      goto_pos(p);
      s       = p % 18;
      exp_sel = (s >= 2 && s < 17) ? ~(4'b0001 << (p / 18)) : 4'hF;
      exp_seg = (s >= 2 && s < 17) ? 8'hA4 : 8'hFF;
      chk($sformatf("latest_sel_p%0d", p), 16'(bus.sel), 16'(exp_sel));
      chk($sformatf("latest_seg_p%0d", p), 16'(bus.seg), 16'(exp_seg));
    end
    goto_pos(70);
    load_pulse(16'h3333, 4'h0, 4'h0, 4'h0);
    chk("busy_commit_cycle_load", 16'(bus.busy), 16'h1);

    // F5: the late load waits a full frame
    sync_frame();
    chk("f5_busy0", 16'(bus.busy), 16'h1);
    goto_pos(2);
    chk("f5_old_seg", 16'(bus.seg), 16'hA4);
    goto_pos(40);
    chk("f5_busy40", 16'(bus.busy), 16'h1);

    // F6: 3333 shown; load blank on digit 3
    sync_frame();
    chk("f6_busy", 16'(bus.busy), 16'h0);
    goto_pos(2);
    chk("f6_seg", 16'(bus.seg), 16'hB0);
    goto_pos(10);
    load_pulse(16'h3210, 4'h0, 4'b1000, 4'h0);

    // F7: digit 3 blanked; load B on digit 1 with dp
    sync_frame();
    goto_pos(38);
    chk("blank_d2_sel", 16'(bus.sel), 16'hB);
    goto_pos(56);
    chk("blank_d3_sel", 16'(bus.sel), 16'hF);
    chk("blank_d3_seg", 16'(bus.seg), 16'hFF);
    goto_pos(60);
    chk("blank_d3_sel60", 16'(bus.sel), 16'hF);
    load_pulse(16'h00B0, 4'b0010, 4'h0, 4'h0);

    // F8: dp + hex B, then async reset mid-slot
    sync_frame();
    goto_pos(2);
    chk("dp_d0_seg", 16'(bus.seg), 16'hC0);
    goto_pos(20);
    chk("dp_d1_sel", 16'(bus.sel), 16'hD);
    chk("dp_d1_seg", 16'(bus.seg), 16'h03);
    goto_pos(21);
    load_pulse(16'h00B0, 4'b0010, 4'h0, 4'h0);
    chk("pre_rst_busy", 16'(bus.busy), 16'h1);
    chk("pre_rst_seg", 16'(bus.seg), 16'h03);
    rst = 1'b1;
    #1;
    chk("async_rst_seg", 16'(bus.seg), 16'hFF);
    chk("async_rst_sel", 16'(bus.sel), 16'hF);
    chk("async_rst_busy", 16'(bus.busy), 16'h0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    cur_pos = 71;

    // Blink: G0 load, G1 lit, G2/G3 dark, G4 lit; digit 1 unaffected
    sync_frame();
    load_pulse(16'h3210, 4'h0, 4'h0, 4'b0001);
    for (int g = 1; g <= 4; g++) begin
      sync_frame();
      goto_pos(2);
      chk($sformatf("blink_d0_g%0d", g), 16'(bus.sel), (g == 1 || g == 4) ? 16'hE : 16'hF);
      goto_pos(20);
      chk($sformatf("blink_d1_g%0d", g), 16'(bus.sel), 16'hD);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_7seg_scan_ctrl.md
Name: led_7seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment scan controller, successor to the fixed 4-digit scanner in the LED demo designs. It drives DIGITS common-select digits from one system clock with a built-in slot timer, so no separate ms-clock divider is needed. It adds hex decode, per-digit decimal point, blank and blink, 16-level PWM brightness, anti-ghost guard time, polarity parameters and tear-free double-buffered loading. It sits between user logic or the key/counter blocks and the board segment and select pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
GUARD_CLKS, 2000, clocks at start of each slot with all selects off (anti-ghost, >=1)
STEP_CLKS, 3000, clocks per PWM step; slot length SLOT = GUARD_CLKS + 16*STEP_CLKS
BLINK_FRAMES, 32, frames per blink half-period (>=1)
SEG_ACTIVE_LOW, 1, 1: segment lit when pin is 0
SEL_ACTIVE_LOW, 1, 1: digit selected when pin is 0

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active high
load  input  1  one-cycle strobe, captures display inputs into pending buffer
digit_data  input  4*DIGITS  hex nibble per digit, digit d at [4d+3:4d]
dp  input  DIGITS  decimal point per digit
blank_mask  input  DIGITS  1 = digit dark
blink_mask  input  DIGITS  1 = digit blinks
brightness  input  4  PWM duty 0..15 (sampled live, not buffered)
seg  output  8  bit0=a..bit6=g, bit7=dp, polarity per SEG_ACTIVE_LOW
sel  output  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW
busy  output  1  pending buffer not yet committed
frame_start  output  1  one-cycle pulse aligned with first output cycle of digit 0 slot

Behaviour:
- Reset (async, rst=1): slot_cnt=0, digit_idx=0, frame counter=0, blink phase=0, pending_valid=0. Active and pending buffers: data=0, dp=0, blank_mask all 1, blink_mask=0. Outputs: seg all inactive (8'hFF when SEG_ACTIVE_LOW), sel all inactive, busy=0, frame_start=0. Release of rst mid-frame restarts at digit 0, slot_cnt 0.
- Timing: slot_cnt counts 0..SLOT-1, then wraps and digit_idx increments; digit_idx wraps DIGITS-1 -> 0. One frame = DIGITS*SLOT clocks.
- Outputs are registered: state (digit_idx, slot_cnt) at cycle N appears on seg/sel/frame_start at cycle N+1.
- Phase within slot: slot_cnt < GUARD_CLKS -> guard, all sel inactive, seg inactive. Otherwise step = (slot_cnt-GUARD_CLKS)/STEP_CLKS, computed with a step counter, not a divider. Digit on iff step < brightness. brightness=0 gives dark; 15 gives 15/16 duty.
- When on: sel asserts bit digit_idx only. seg = decode(nibble) with bit7=dp[d]. Decode table (active-high): 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
- blank_mask[d]=1, or (blink_mask[d]=1 and blink phase=1) -> seg inactive and sel inactive for whole slot.
- Blink: frame counter increments at each frame wrap; after BLINK_FRAMES frames it resets to 0 and blink phase toggles.
- Load/commit: load=1 copies digit_data, dp, blank_mask, blink_mask into pending and sets pending_valid. Commit happens at the last clock of a frame (digit_idx=DIGITS-1, slot_cnt=SLOT-1) if pending_valid: active<=pending, pending_valid<=0. A digit never changes mid-frame. busy = pending_valid (registered).
- Load while busy: pending is overwritten, latest wins, and only the latest value is committed.
- Load in the commit cycle: the old pending is committed, the new load becomes pending, and busy stays 1. Load with pending_valid=0 in the commit cycle is not committed until the next frame boundary.
- brightness changes take effect on the next clock; no buffering.

Test Plan:
(All scenarios: DIGITS=4, GUARD_CLKS=2, STEP_CLKS=1, BLINK_FRAMES=2, so SLOT=18 and frame=72 clocks; both polarities active-low.)
- Reset then idle -> seg=8'hFF, sel=4'hF, busy=0; frame_start pulses every 72 clocks; rst pulse mid-slot -> outputs return to inactive immediately, asynchronously.
- load digit_data=16'h3210, dp=0, blank=0, blink=0, brightness=15 -> busy=1 until frame end. Next frame, digit 0 slot: 2 clocks sel=4'hF, then 15 clocks sel=4'hE with seg=~8'h3F, then 1 clock off. Digit 1 slot shows seg=~8'h06.
- brightness=4 -> each slot is on exactly 4 clocks after the 2 guard clocks; brightness=0 -> sel stays 4'hF.
- Two loads (16'h1111 then 16'h2222) in the same frame -> only 2222 is displayed next frame, and 1111 never appears. A load in the commit cycle -> busy stays 1 through the following frame.
- blink_mask=4'b0001 -> digit 0 lit for 2 frames, dark for 2 frames, repeating; digits 1-3 unaffected. blank_mask=4'b1000 -> digit 3 never selected.
- dp=4'b0010, data nibble B on digit 1 -> seg=~8'hFC during digit 1 on-time.
